// File: rtl/expr_pkg.sv
// Shared types and constants for the expression arbiter slice.
// Holds the arbiter / recogniser state enums and ASCII helpers.
package expr_pkg;

    // ASCII characters the recogniser understands.
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    // Default expression terminator ('=').
    localparam logic [7:0] TERM_DEFAULT = 8'h3D;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_REPORT,
        ST_FLUSH
    } arb_state_t;

    // Recogniser states: expecting an operand digit,
    // expecting an operator, or latched error.
    typedef enum logic [1:0] {
        CK_OPND,
        CK_OPER,
        CK_ERR
    } chk_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_MUL);
    endfunction

endpackage

// File: rtl/expr_check.sv
// Expression recogniser for the grammar  digit (op digit)*,
// op in {'+','*'}. Moore FSM with a latched error state.
//
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-high clear (back to empty)
//   en   feed 'in' this cycle
//   in   ASCII byte
//   out  registered: 1 iff bytes since clear are a valid
//        prefix ending in a digit
module expr_check
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] in,
    output logic       out
);

    chk_state_t state;

    // 'out' is registered alongside the state so it is
    // exactly (state == CK_OPER) without a decode path.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= CK_OPND;
            out   <= 1'b0;
        end else if (en) begin
            unique case (state)
                CK_OPND: begin
                    if (is_digit(in)) begin
                        state <= CK_OPER;
                        out   <= 1'b1;
                    end else begin
                        state <= CK_ERR;
                        out   <= 1'b0;
                    end
                end
                CK_OPER: begin
                    // A second digit is illegal: operands
                    // are single digits.
                    if (is_op(in)) begin
                        state <= CK_OPND;
                        out   <= 1'b0;
                    end else begin
                        state <= CK_ERR;
                        out   <= 1'b0;
                    end
                end
                default: begin
                    state <= CK_ERR;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin arbiter sharing one expression recogniser
// between two byte-stream requesters, one expression at a time.
//
// Ports:
//   clk, clr                 clock, async active-high reset
//   req0_valid/data/ready    requester 0 byte stream
//   req1_valid/data/ready    requester 1 byte stream
//   res_valid/res_id/res_ok  one-cycle tagged verdict
//   busy                     high outside IDLE
// Optional: define EXPR_TIMEOUT_EN to abort an expression
// after TMO_CYCLES consecutive stalled cycles in STREAM.
module expr_arbiter
    import expr_pkg::*;
#(
    parameter logic [7:0]  TERM       = TERM_DEFAULT,
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       res_valid,
    output logic       res_id,
    output logic       res_ok,
    output logic       busy
);

    arb_state_t state;
    logic       grant;
    logic       last_grant;
    logic       flush;
    logic       pick;

    logic       g_valid;
    logic [7:0] g_data;
    logic       accept;
    logic       term_seen;
    logic       feed;
    logic       tmo;

    logic       chk_clr;
    logic       chk_out;

    // Granted-side view of the byte stream.
    assign g_valid = grant ? req1_valid : req0_valid;
    assign g_data  = grant ? req1_data  : req0_data;

    // Ready is only ever high for the granted side in STREAM.
    assign accept = grant ? (req1_valid & req1_ready)
                          : (req0_valid & req0_ready);

    assign term_seen = accept && (g_data == TERM);
    assign feed      = accept && (g_data != TERM);

    // Single requester wins outright; on a tie the one that
    // was not served last goes first.
    assign pick = (req0_valid && req1_valid) ? ~last_grant
                                             : req1_valid;

    // flush is a flop output, so OR-ing it into the async
    // clear does not introduce a combinational glitch.
    assign chk_clr = clr | flush;

    expr_check u_check (
        .clk (clk),
        .clr (chk_clr),
        .en  (feed),
        .in  (g_data),
        .out (chk_out)
    );

`ifdef EXPR_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] idle_cnt;

    // Fires on the TMO_CYCLES-th consecutive stalled cycle.
    assign tmo = (state == ST_STREAM) && !g_valid &&
                 (idle_cnt == CW'(TMO_CYCLES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idle_cnt <= '0;
        end else if (state != ST_STREAM || g_valid) begin
            idle_cnt <= '0;
        end else if (!tmo) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign unused_tmo = ^TMO_CYCLES;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            flush      <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
            res_ok     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant      <= pick;
                        req0_ready <= ~pick;
                        req1_ready <= pick;
                        busy       <= 1'b1;
                        state      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // A timeout reports like a terminator but
                    // always with a negative verdict.
                    if (term_seen || tmo) begin
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        res_valid  <= 1'b1;
                        res_id     <= grant;
                        res_ok     <= term_seen & chk_out;
                        state      <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    res_valid  <= 1'b0;
                    res_ok     <= 1'b0;
                    last_grant <= grant;
                    flush      <= 1'b1;
                    state      <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    flush <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_arbiter.sv
// Self-checking bench for expr_arbiter: directed steps plus
// randomized rounds checked against a grammar/arbitration model.
module tb_expr_arbiter;

    localparam logic [7:0] TERM = 8'h3D;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic id;
        logic ok;
        int   cyc;
    } verd_t;
    typedef struct {
        logic id;
        logic ok;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       res_valid;
    logic       res_id;
    logic       res_ok;
    logic       busy;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    both_ready = 1'b0;
    verd_t vq[$];

    expr_arbiter dut (
        .clk        (clk),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_ok     (res_ok),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid)
            vq.push_back('{id: res_id, ok: res_ok, cyc: cyc});
        if (req0_ready && req1_ready)
            both_ready = 1'b1;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Spec-level grammar: odd length, digits at even
    // positions, '+'/'*' at odd positions.
    function automatic logic model_ok(input bq_t e);
        if (e.size() == 0 || (e.size() % 2) == 0)
            return 1'b0;
        for (int i = 0; i < e.size(); i++) begin
            if (i % 2 == 0) begin
                if (e[i] < 8'h30 || e[i] > 8'h39)
                    return 1'b0;
            end else begin
                if (e[i] != 8'h2B && e[i] != 8'h2A)
                    return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // Mostly well-formed bodies with occasional illegal bytes.
    function automatic bq_t gen();
        bq_t        q;
        int         len;
        logic [7:0] c;
        len = $urandom_range(0, 6);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: c = 8'h78;
                    1: c = 8'h2D;
                    2: c = 8'h30 + 8'($urandom_range(0, 9));
                    default: c = 8'h2B;
                endcase
            end else if (i % 2 == 0) begin
                c = 8'h30 + 8'($urandom_range(0, 9));
            end else begin
                c = $urandom_range(0, 1) ? 8'h2B : 8'h2A;
            end
            q.push_back(c);
        end
        return q;
    endfunction

    task automatic drive(input bit who, input logic v,
                         input logic [7:0] d);
        if (who) begin
            req1_valid = v;
            req1_data  = d;
        end else begin
            req0_valid = v;
            req0_data  = d;
        end
    endtask

    // Sends every byte of e; last = cycle the final byte
    // was accepted (edge ending that cycle).
    task automatic send(input bit who, input bq_t e,
                        input bit gaps, output int last);
        int n;
        int k;
        last = -1;
        for (int i = 0; i < e.size(); i++) begin
            drive(who, 1'b1, e[i]);
            n = 0;
            @(negedge clk);
            while (!(who ? req1_ready : req0_ready)) begin
                n++;
                if (n > 300) begin
                    tests++;
                    fails++;
                    $error("FAIL ready_timeout: req%0d byte %0d observed no ready expected ready",
                           who, i);
                    drive(who, 1'b0, 8'h00);
                    return;
                end
                @(negedge clk);
            end
            last = cyc;
            @(posedge clk);
            #1;
            if (gaps) begin
                k = $urandom_range(0, 2);
                if (k > 0) begin
                    drive(who, 1'b0, 8'h00);
                    repeat (k) @(posedge clk);
                    #1;
                end
            end
        end
        drive(who, 1'b0, 8'h00);
    endtask

    task automatic get_verdict(output verd_t v);
        v = '{id: 1'bx, ok: 1'bx, cyc: -1};
        for (int i = 0; i < 400 && vq.size() == 0; i++)
            @(negedge clk);
        if (vq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL verdict_timeout: observed no res_valid expected a verdict");
        end else begin
            v = vq.pop_front();
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs",
              32'({req0_ready, req1_ready, res_valid,
                   res_id, res_ok, busy}), 32'd0);
        @(posedge clk);
        #1 clr = 1'b0;
        vq.delete();
    endtask

    verd_t v;
    exp_t  eq[$];
    exp_t  x;
    bq_t   b0;
    bq_t   b1;
    logic  ok0;
    logic  ok1;
    logic  lg;
    int    lc0;
    int    lc1;
    int    nq;
    int    mode;

    initial begin
        do_reset();

        // Well-formed expression, back-to-back bytes.
        b0 = '{8'h31, 8'h2B, 8'h32, 8'h2A, 8'h33, TERM};
        send(1'b0, b0, 1'b0, lc0);
        get_verdict(v);
        check("t1_id", 32'(v.id), 32'd0);
        check("t1_ok", 32'(v.ok), 32'd1);
        check("t1_lat", 32'(v.cyc - lc0), 32'd1);

        // Trailing operator, then a clean one on the same side.
        b1 = '{8'h31, 8'h2B, TERM};
        send(1'b1, b1, 1'b0, lc1);
        get_verdict(v);
        check("t2_id", 32'(v.id), 32'd1);
        check("t2_ok", 32'(v.ok), 32'd0);
        check("t2_lat", 32'(v.cyc - lc1), 32'd1);
        b1 = '{8'h35, TERM};
        send(1'b1, b1, 1'b0, lc1);
        get_verdict(v);
        check("t2b_id", 32'(v.id), 32'd1);
        check("t2b_ok", 32'(v.ok), 32'd1);

        // Ties from reset: requester 0 first, twice.
        do_reset();
        both_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            b0 = '{8'h37, TERM};
            b1 = '{8'h37, TERM};
            fork
                send(1'b0, b0, 1'b0, lc0);
                send(1'b1, b1, 1'b0, lc1);
            join
            get_verdict(v);
            check("tie_first_id", 32'(v.id), 32'd0);
            check("tie_first_ok", 32'(v.ok), 32'd1);
            get_verdict(v);
            check("tie_second_id", 32'(v.id), 32'd1);
            check("tie_second_ok", 32'(v.ok), 32'd1);
        end

        // Empty expression.
        b0 = '{TERM};
        send(1'b0, b0, 1'b0, lc0);
        get_verdict(v);
        check("empty_id", 32'(v.id), 32'd0);
        check("empty_ok", 32'(v.ok), 32'd0);
        repeat (4) @(negedge clk);

        // Reset in the middle of an expression.
        b0 = '{8'h31, 8'h2B};
        send(1'b0, b0, 1'b0, lc0);
        nq = vq.size();
        clr = 1'b1;
        @(negedge clk);
        check("clr_outs",
              32'({req0_ready, req1_ready, res_valid,
                   res_id, res_ok, busy}), 32'd0);
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_no_verdict", 32'(vq.size()), 32'(nq));
        b0 = '{8'h32, TERM};
        send(1'b0, b0, 1'b0, lc0);
        get_verdict(v);
        check("clr_after_id", 32'(v.id), 32'd0);
        check("clr_after_ok", 32'(v.ok), 32'd1);

        // Randomized rounds against the model.
        do_reset();
        lg = 1'b1;
        for (int r = 0; r < 24; r++) begin
            mode = $urandom_range(0, 2);
            b0 = gen();
            b1 = gen();
            ok0 = model_ok(b0);
            ok1 = model_ok(b1);
            b0.push_back(TERM);
            b1.push_back(TERM);
            eq.delete();
            if (mode == 0) begin
                eq.push_back('{id: 1'b0, ok: ok0});
                lg = 1'b0;
                send(1'b0, b0, 1'b1, lc0);
            end else if (mode == 1) begin
                eq.push_back('{id: 1'b1, ok: ok1});
                lg = 1'b1;
                send(1'b1, b1, 1'b1, lc1);
            end else begin
                // The side not served last goes first; the
                // other side then becomes the last served.
                if (lg) begin
                    eq.push_back('{id: 1'b0, ok: ok0});
                    eq.push_back('{id: 1'b1, ok: ok1});
                end else begin
                    eq.push_back('{id: 1'b1, ok: ok1});
                    eq.push_back('{id: 1'b0, ok: ok0});
                end
                fork
                    send(1'b0, b0, 1'b1, lc0);
                    send(1'b1, b1, 1'b1, lc1);
                join
            end
            while (eq.size() > 0) begin
                x = eq.pop_front();
                get_verdict(v);
                check("rnd_id", 32'(v.id), 32'(x.id));
                check("rnd_ok", 32'(v.ok), 32'(x.ok));
            end
        end

`ifdef EXPR_TIMEOUT_EN
        // Stalled stream aborts with a negative verdict.
        do_reset();
        b0 = '{8'h34};
        send(1'b0, b0, 1'b0, lc0);
        get_verdict(v);
        check("tmo_id", 32'(v.id), 32'd0);
        check("tmo_ok", 32'(v.ok), 32'd0);
        check("tmo_lat", 32'(v.cyc - lc0), 32'd17);
        repeat (3) @(negedge clk);
        check("tmo_idle", 32'(busy), 32'd0);
`endif

        repeat (6) @(negedge clk);
        check("excl_ready", 32'(both_ready), 32'd0);
        check("idle_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
